// File: rtl/data_lsu.sv
// Load/store unit with a local word-organised data memory and programmable wait states.
// Optional misalignment trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
module data_lsu #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_MemReq,
  input  logic        i_MemWrite,
  input  logic [2:0]  i_Funct3,
  input  logic [31:0] i_ALUResult,
  input  logic [31:0] i_WriteData,
  output logic [31:0] o_ReadData,
  output logic        o_Valid,
  output logic        o_Stall,
  output logic        o_Misaligned
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t         r_State;
  logic [3:0]     r_Cnt;
  logic [AW+1:0]  r_Addr;
  logic [31:0]    r_Data;
  logic [2:0]     r_Funct3;
  logic           r_Write;
  logic [31:0]    r_Mem [DEPTH_WORDS];

  logic [AW-1:0]  w_Idx;
  logic [31:0]    w_Word;
  logic           w_Illegal;
  logic           w_IsByte;
  logic           w_IsHalf;
  logic           w_DoAccess;
  logic [7:0]     w_Byte;
  logic [15:0]    w_Half;
  logic [31:0]    w_LoadVal;
  logic [31:0]    w_StoreWord;
  logic           w_unused_addr;

  // Address bits above the memory index only alias the same words.
  assign w_unused_addr = &{1'b0, i_ALUResult[31:AW+2]};

  assign w_Idx      = r_Addr[AW+1:2];
  assign w_Word     = r_Mem[w_Idx];
  assign w_Illegal  = (r_Funct3 == 3'b011) || (r_Funct3 == 3'b110) || (r_Funct3 == 3'b111) ||
                      (r_Write && r_Funct3[2]);
  assign w_IsByte   = !w_Illegal && (r_Funct3[1:0] == 2'b00);
  assign w_IsHalf   = !w_Illegal && (r_Funct3[1:0] == 2'b01);
  assign w_DoAccess = (r_State == S_WAIT) && (r_Cnt == 4'd0);

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_AccMis;
  assign w_AccMis = (i_Funct3 == 3'b011) || (i_Funct3 == 3'b110) || (i_Funct3 == 3'b111) ||
                    (i_MemWrite && i_Funct3[2]) ||
                    ((i_Funct3[1:0] == 2'b01) && i_ALUResult[0]) ||
                    ((i_Funct3[1:0] == 2'b10) && (i_ALUResult[1:0] != 2'b00));
`endif

  // Without trapping, a misaligned half drops addr[0] and a word ignores addr[1:0].
  always_comb begin
    w_Byte    = w_Word[{r_Addr[1:0], 3'b000} +: 8];
    w_Half    = w_Word[{r_Addr[1], 4'b0000} +: 16];
    w_LoadVal = w_Word;
    if (w_IsByte) begin
      w_LoadVal = r_Funct3[2] ? {24'd0, w_Byte} : {{24{w_Byte[7]}}, w_Byte};
    end else if (w_IsHalf) begin
      w_LoadVal = r_Funct3[2] ? {16'd0, w_Half} : {{16{w_Half[15]}}, w_Half};
    end
  end

  always_comb begin
    w_StoreWord = w_Word;
    if (w_IsByte) begin
      w_StoreWord[{r_Addr[1:0], 3'b000} +: 8] = r_Data[7:0];
    end else if (w_IsHalf) begin
      w_StoreWord[{r_Addr[1], 4'b0000} +: 16] = r_Data[15:0];
    end else begin
      w_StoreWord = r_Data;
    end
  end

  assign o_Stall = ((r_State == S_IDLE) && i_MemReq) || (r_State == S_WAIT);

  // Memory contents survive reset; reset forces IDLE so a pending store never lands.
  always_ff @(posedge i_Clk) begin
    if (w_DoAccess && r_Write) begin
      r_Mem[w_Idx] <= w_StoreWord;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_State      <= S_IDLE;
      r_Cnt        <= 4'd0;
      r_Addr       <= '0;
      r_Data       <= 32'd0;
      r_Funct3     <= 3'd0;
      r_Write      <= 1'b0;
      o_ReadData   <= 32'd0;
      o_Valid      <= 1'b0;
      o_Misaligned <= 1'b0;
    end else begin
      case (r_State)
        S_IDLE: begin
          o_Valid      <= 1'b0;
          o_Misaligned <= 1'b0;
          if (i_MemReq) begin
            r_Addr   <= i_ALUResult[AW+1:0];
            r_Data   <= i_WriteData;
            r_Funct3 <= i_Funct3;
            r_Write  <= i_MemWrite;
            r_Cnt    <= 4'(WAIT_CYCLES);
            r_State  <= S_WAIT;
`ifdef LSU_MISALIGN_TRAP_EN
            if (w_AccMis) begin
              r_State      <= S_RESP;
              o_Valid      <= 1'b1;
              o_Misaligned <= 1'b1;
              o_ReadData   <= 32'd0;
            end
`endif
          end
        end
        S_WAIT: begin
          if (r_Cnt != 4'd0) begin
            r_Cnt <= r_Cnt - 4'd1;
          end else begin
            r_State      <= S_RESP;
            o_Valid      <= 1'b1;
            o_Misaligned <= 1'b0;
            o_ReadData   <= r_Write ? 32'd0 : w_LoadVal;
          end
        end
        default: begin
          o_Valid      <= 1'b0;
          o_Misaligned <= 1'b0;
          r_State      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_lsu.sv
// Bench for data_lsu: transaction-level memory model, per-cycle output comparison,
// directed literal cases and randomized accesses (honours LSU_MISALIGN_TRAP_EN).
module tb_data_lsu;
  localparam int DEPTH = 1024;
  localparam int W     = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [2:0]  f3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] o_ReadData;
  logic        o_Valid;
  logic        o_Stall;
  logic        o_Misaligned;

  data_lsu #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_MemReq(req), .i_MemWrite(wr), .i_Funct3(f3),
    .i_ALUResult(addr), .i_WriteData(wdata), .o_ReadData(o_ReadData), .o_Valid(o_Valid),
    .o_Stall(o_Stall), .o_Misaligned(o_Misaligned)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  logic        chk_en = 1'b0;
  logic        exp_valid = 1'b0;
  logic        exp_stall = 1'b0;
  logic        exp_mis = 1'b0;
  logic [31:0] exp_rd = 32'd0;
  logic [31:0] mm [16];

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, got, exp);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", {31'd0, o_Valid}, {31'd0, exp_valid});
      check("stall", {31'd0, o_Stall}, {31'd0, exp_stall});
      check("misaligned", {31'd0, o_Misaligned}, {31'd0, exp_mis});
      if (exp_valid) check("rdata", o_ReadData, exp_rd);
    end
  end

  // Reference: memory as 16 words addressed by a[5:2]; sizes in bytes, lanes by byte offset.
  function automatic void model(input logic w, input logic [2:0] f, input logic [31:0] a,
                                input logic [31:0] d, output logic trap, output logic [31:0] rd);
    logic illegal;
    int size, off, idx;
    logic [31:0] word, v;
    illegal = (f == 3) || (f == 6) || (f == 7) || (w && f[2]);
    trap = 1'b0;
    rd = 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (illegal || (f[1:0] == 2'b01 && a[0]) || (f[1:0] == 2'b10 && a[1:0] != 2'b00)) begin
      trap = 1'b1;
      return;
    end
`endif
    size = illegal ? 4 : (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
    off  = (size == 1) ? int'(a[1:0]) : (size == 2) ? 2 * int'(a[1]) : 0;
    idx  = int'(a[5:2]);
    word = mm[idx];
    if (w) begin
      for (int k = 0; k < size; k++) word[8*(off+k) +: 8] = d[8*k +: 8];
      mm[idx] = word;
    end else begin
      v = 32'd0;
      for (int k = 0; k < size; k++) v[8*k +: 8] = word[8*(off+k) +: 8];
      if (!f[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
      rd = v;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_access(input logic w, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] rd_out, output logic mis_out);
    logic trap;
    logic [31:0] rd;
    model(w, f, a, d, trap, rd);
    req = 1'b1; wr = w; f3 = f; addr = a; wdata = d;
    exp_stall = 1'b1; exp_valid = 1'b0; exp_mis = 1'b0;
    step();
    // Live inputs are scrambled while waiting; only the captured request may matter.
    repeat (trap ? 0 : W + 1) begin
      wr = 1'($urandom); f3 = 3'($urandom); addr = $urandom; wdata = $urandom;
      exp_stall = 1'b1;
      step();
    end
    req = 1'b0;
    exp_valid = 1'b1; exp_stall = 1'b0; exp_mis = trap; exp_rd = rd;
    @(negedge clk);
    rd_out = o_ReadData;
    mis_out = o_Misaligned;
    step();
    exp_valid = 1'b0; exp_mis = 1'b0; exp_stall = 1'b0;
  endtask

  task automatic dir(input string nm, input logic w, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] erd, input logic emis);
    logic [31:0] rd;
    logic mis;
    do_access(w, f, a, d, rd, mis);
    check(nm, rd, erd);
    check({nm, "_mis"}, {31'd0, mis}, {31'd0, emis});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic mis;
    logic [2:0] f;
    logic [31:0] a;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rdata", o_ReadData, 32'd0);
    check("reset_valid", {31'd0, o_Valid}, 32'd0);
    check("reset_stall", {31'd0, o_Stall}, 32'd0);
    check("reset_mis", {31'd0, o_Misaligned}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk_en = 1'b1;

    for (int i = 0; i < 16; i++)
      do_access(1'b1, 3'b010, 32'(i * 4), (i == 4) ? 32'h12345678 : $urandom, rd, mis);

    // Reset in the middle of a store's wait: store dropped, outputs clear at once.
    req = 1'b1; wr = 1'b1; f3 = 3'b010; addr = 32'h10; wdata = 32'hDEADBEEF;
    exp_stall = 1'b1;
    step();
    step();
    rst_n = 1'b0; req = 1'b0; exp_stall = 1'b0; exp_valid = 1'b0;
    @(negedge clk);
    check("midreset_rdata", o_ReadData, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    dir("lw_after_reset", 1'b0, 3'b010, 32'h10, 32'd0, 32'h12345678, 1'b0);

    dir("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
    dir("lw_10", 1'b0, 3'b010, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
    dir("sb_13", 1'b1, 3'b000, 32'h13, 32'h80, 32'd0, 1'b0);
    dir("lb_13", 1'b0, 3'b000, 32'h13, 32'd0, 32'hFFFFFF80, 1'b0);
    dir("lbu_13", 1'b0, 3'b100, 32'h13, 32'd0, 32'h00000080, 1'b0);
    dir("lw_10_merged", 1'b0, 3'b010, 32'h10, 32'd0, 32'h80ADBEEF, 1'b0);
    dir("sh_22", 1'b1, 3'b001, 32'h22, 32'h8001, 32'd0, 1'b0);
    dir("lh_22", 1'b0, 3'b001, 32'h22, 32'd0, 32'hFFFF8001, 1'b0);
    dir("lhu_22", 1'b0, 3'b101, 32'h22, 32'd0, 32'h00008001, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    dir("lw_12", 1'b0, 3'b010, 32'h12, 32'd0, 32'd0, 1'b1);
    dir("sw_11_trap", 1'b1, 3'b010, 32'h11, 32'h55555555, 32'd0, 1'b1);
`else
    dir("lw_12", 1'b0, 3'b010, 32'h12, 32'd0, 32'h80ADBEEF, 1'b0);
`endif
    dir("lw_10_unchanged", 1'b0, 3'b010, 32'h10, 32'd0, 32'h80ADBEEF, 1'b0);
    dir("lw_wrap", 1'b0, 3'b010, 32'(4 * DEPTH + 'h10), 32'd0, 32'h80ADBEEF, 1'b0);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0: f = 3'b000;
        1: f = 3'b001;
        2: f = 3'b010;
        3: f = 3'b100;
        4: f = 3'b101;
        default: f = 3'($urandom);
      endcase
      a = {26'd0, 4'($urandom), 2'($urandom)} + 32'($urandom_range(0, 3) * 4 * DEPTH);
      do_access(1'($urandom), f, a, $urandom, rd, mis);
      repeat ($urandom_range(0, 2)) step();
    end
    for (int i = 0; i < 16; i++) begin
      do_access(1'b0, 3'b010, 32'(i * 4), 32'd0, rd, mis);
      check("final_readback", rd, mm[i]);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
